ame_matrix_accumulator: RTL and testbench
=========================================

Name: ame_matrix_accumulator

Overview:
- Upstream feeder of the affine-ME linear equation solver.
- Consumes a stream of per-pixel samples: gradients gx/gy, position x/y, temporal difference diff.
- Builds the symmetric normal-equation matrix A[6][6] and vector B[6] in 64-bit accumulators.
- Presents A and B as the solver's augmented 6x7 input, and holds comp_init_o high until the solver reports done.

Parameters:
- GRAD_BITS, 16, signed width of gx, gy.
- POS_BITS, 8, unsigned width of x, y (offset within block).
- DIFF_BITS, 16, signed width of diff.
- COMP_DATA_BITS, 64, signed accumulator/output word width.

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous reset, active-high
- accum_init_i  in  1  start new block (accepted only in IDLE)
- affine_param6_i  in  1  1 = 6-param model, 0 = 4-param; latched at accum_init_i
- sample_valid_i  in  1  sample present
- sample_ready_o  out  1  sample accepted when valid & ready
- sample_last_i  in  1  final sample of block
- sample_gx_i, sample_gy_i  in  GRAD_BITS each  signed gradients
- sample_x_i, sample_y_i  in  POS_BITS each  unsigned position
- sample_diff_i  in  DIFF_BITS  signed temporal difference
- comp_init_o  out  1  matrix valid / solver start (level)
- comp_done_i  in  1  solver finished
- affine_param6_o  out  1  latched mode, to solver
- comp_data_o  out  6x7xCOMP_DATA_BITS  [r][c] = A[r][c] for c=0..5; [r][6] = B[r]

Behaviour:
- Reset values: all accumulators 0, comp_data_o 0, comp_init_o 0, sample_ready_o 0, affine_param6_o 0, state IDLE.
- FSM states: IDLE, ACCUM, DRAIN, HOLD.
- IDLE -> ACCUM on accum_init_i: clear all accumulators, latch mode. accum_init_i in any other state is ignored.
- ACCUM: sample_ready_o=1. Stays on accepted samples. On accepted sample with sample_last_i=1 -> DRAIN. Valid-low cycles are bubbles: nothing accumulated.
- DRAIN: sample_ready_o=0. Counts 3 cycles, then -> HOLD.
- HOLD: comp_init_o=1, comp_data_o stable. Leave on comp_done_i=1 -> IDLE (comp_init_o=0 next cycle). comp_done_i in other states is ignored.
- Samples with valid=1 outside ACCUM are not accepted and have no effect.
- Pipeline, 3 registered stages:
  - S1: vector c[0..5], sign-extended to COMP_DATA_BITS.
    - 6-param: c = {gx, x*gx, gy, x*gy, y*gx, y*gy}.
    - 4-param: c0=c1=0, c2=x*gx+y*gy, c3=y*gx-x*gy, c4=gx, c5=gy.
  - S2: 21 upper-triangle products c[i]*c[j] (i<=j), plus 6 products c[i]*diff.
  - S3: add S2 products into accumulators.
- Lower triangle is mirrored: A[j][i] outputs the A[i][j] register.
- Latency: last sample accepted at cycle N -> its contribution lands at edge N+3 -> comp_init_o=1 from cycle N+4.
- Arithmetic: signed two's complement throughout, modulo 2^COMP_DATA_BITS (wrap, no saturation).
- In 4-param mode, rows/cols 0 and 1 (including B0, B1) read 0.
- Block with a single sample whose last=1 is legal.
- rst_i mid-operation: immediate return to IDLE, pipeline flushed, all outputs at reset values.

Test Plan:
- 6-param single sample gx=1, gy=2, x=3, y=4, diff=5, last=1 -> c={1,3,2,6,4,8}. Expect A[1][3]=A[3][1]=18, A[5][5]=64, A[0][0]=1, B[0]=5, B[5]=40. comp_init_o high exactly 4 cycles after acceptance; affine_param6_o=1.
- 4-param, same sample -> c2=11, c3=-2. Expect A[2][2]=121, A[2][3]=A[3][2]=-22, A[4][5]=2, B[3]=-10; row/col 0,1 all zero.
- 6-param, two samples (gx=-1, gy=0, x=0, y=0, diff=3) then (gx=-1, gy=0, x=2, y=0, diff=-3, last) with one bubble between -> A[0][0]=2, A[0][1]=2, A[1][1]=4, B[0]=0, B[1]=6.
- Hold/handshake: in HOLD, drive samples and accum_init_i -> ignored, data unchanged, sample_ready_o=0. comp_done_i pulse -> comp_init_o low next cycle; new accum_init_i clears A to 0.
- Reset mid-ACCUM after 2 samples -> all outputs 0, state IDLE. Fresh block of one sample yields only that sample's values.
- Wrap: accumulate 2 samples each contributing A[0][0]=2^62 (gx=2^31 with GRAD_BITS=32) -> A[0][0]=-2^63.

Source files
------------

// File: rtl/ame_matrix_accumulator_if.sv
// ame_matrix_accumulator_if: sample stream, solver handshake and augmented matrix bus
interface ame_matrix_accumulator_if #(
  parameter int GRAD_BITS = 16,
  parameter int POS_BITS = 8,
  parameter int DIFF_BITS = 16,
  parameter int COMP_DATA_BITS = 64
);
  logic accum_init_i;
  logic affine_param6_i;
  logic sample_valid_i;
  logic sample_ready_o;
  logic sample_last_i;
  logic signed [GRAD_BITS-1:0] sample_gx_i;
  logic signed [GRAD_BITS-1:0] sample_gy_i;
  logic [POS_BITS-1:0] sample_x_i;
  logic [POS_BITS-1:0] sample_y_i;
  logic signed [DIFF_BITS-1:0] sample_diff_i;
  logic comp_init_o;
  logic comp_done_i;
  logic affine_param6_o;
  logic [5:0][6:0][COMP_DATA_BITS-1:0] comp_data_o;
  modport master (
    output accum_init_i, affine_param6_i, sample_valid_i, sample_last_i,
    output sample_gx_i, sample_gy_i, sample_x_i, sample_y_i, sample_diff_i, comp_done_i,
    input sample_ready_o, comp_init_o, affine_param6_o, comp_data_o
  );
  modport slave (
    input accum_init_i, affine_param6_i, sample_valid_i, sample_last_i,
    input sample_gx_i, sample_gy_i, sample_x_i, sample_y_i, sample_diff_i, comp_done_i,
    output sample_ready_o, comp_init_o, affine_param6_o, comp_data_o
  );
endinterface

// File: rtl/ame_matrix_accumulator.sv
// ame_matrix_accumulator: builds affine-ME normal equations A[6][6], B[6] for the solver
module ame_matrix_accumulator #(
  parameter int GRAD_BITS = 16,
  parameter int POS_BITS = 8,
  parameter int DIFF_BITS = 16,
  parameter int COMP_DATA_BITS = 64
) (
  input logic clk_i,
  input logic rst_i,
  ame_matrix_accumulator_if.slave bus
);
  localparam int W = COMP_DATA_BITS;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;
  state_t r_state, w_next;
  logic [1:0] r_cnt;
  logic r_mode, r_v1, r_v2, w_acc, w_clr;
  logic signed [W-1:0] w_gx, w_gy, w_x, w_y, w_d, r_d1;
  logic signed [W-1:0] w_c [6];
  logic signed [W-1:0] r_c1 [6];
  assign w_acc = r_state == ACCUM && bus.sample_valid_i;
  assign w_clr = r_state == IDLE && bus.accum_init_i;
  assign w_gx = W'(bus.sample_gx_i);
  assign w_gy = W'(bus.sample_gy_i);
  assign w_x = W'(bus.sample_x_i);
  assign w_y = W'(bus.sample_y_i);
  assign w_d = W'(bus.sample_diff_i);
  // next state and handshake outputs, all decoded from the state register
  always_comb begin
    w_next = r_state;
    if (w_clr) w_next = ACCUM;
    if (w_acc && bus.sample_last_i) w_next = DRAIN;
    if (r_state == DRAIN && r_cnt == 2'd2) w_next = HOLD;
    if (r_state == HOLD && bus.comp_done_i) w_next = IDLE;
    bus.sample_ready_o = r_state == ACCUM;
    bus.comp_init_o = r_state == HOLD;
    bus.affine_param6_o = r_mode;
  end
  // state, drain counter and mode latched at block start
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_mode <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt <= r_state == DRAIN ? r_cnt + 2'd1 : 2'd0;
      if (w_clr) r_mode <= bus.affine_param6_i;
    end
  end
  // coefficient vector; 4-param mode folds the affine terms and leaves c0, c1 at zero
  always_comb begin
    w_c[0] = r_mode ? w_gx : '0;
    w_c[1] = r_mode ? w_x * w_gx : '0;
    w_c[2] = r_mode ? w_gy : w_x * w_gx + w_y * w_gy;
    w_c[3] = r_mode ? w_x * w_gy : w_y * w_gx - w_x * w_gy;
    w_c[4] = r_mode ? w_y * w_gx : w_gx;
    w_c[5] = r_mode ? w_y * w_gy : w_gy;
  end
  // stage 1: register the coefficient vector and diff of each accepted sample
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_c1 <= '{default: '0};
      r_d1 <= '0;
    end else begin
      r_v1 <= w_acc;
      r_v2 <= r_v1;
      if (w_acc) begin
        r_c1 <= w_c;
        r_d1 <= w_d;
      end
    end
  end
  for (genvar i = 0; i < 6; i++) begin : g_r
    for (genvar j = 0; j < 6; j++) begin : g_c
      if (j >= i) begin : g_u
        logic signed [W-1:0] r_p, r_a;
        // stages 2-3: upper-triangle product, then accumulate; lower triangle mirrors it
        always_ff @(posedge clk_i) begin
          if (rst_i) begin
            r_p <= '0;
            r_a <= '0;
          end else begin
            r_p <= r_c1[i] * r_c1[j];
            r_a <= w_clr ? '0 : r_v2 ? r_a + r_p : r_a;
          end
        end
        assign bus.comp_data_o[i][j] = r_a;
        if (j > i) begin : g_m
          assign bus.comp_data_o[j][i] = r_a;
        end
      end
    end
    logic signed [W-1:0] r_q, r_b;
    // stages 2-3: right-hand side product with diff, then accumulate
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_q <= '0;
        r_b <= '0;
      end else begin
        r_q <= r_c1[i] * r_d1;
        r_b <= w_clr ? '0 : r_v2 ? r_b + r_q : r_b;
      end
    end
    assign bus.comp_data_o[i][6] = r_b;
  end
endmodule

// File: tb/tb_ame_matrix_accumulator.sv
// tb_ame_matrix_accumulator: randomized scoreboard bench against a plain-arithmetic normal-equation model
module tb_ame_matrix_accumulator;
  typedef logic [5:0][6:0][63:0] mat_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ame_matrix_accumulator_if bus ();
  ame_matrix_accumulator_if #(.GRAD_BITS(32)) bus2 ();
  ame_matrix_accumulator dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  ame_matrix_accumulator #(.GRAD_BITS(32)) dut2 (.clk_i(clk), .rst_i(rst), .bus(bus2));
  mat_t q[$];
  bit qm[$];
  int total = 0;
  int bad = 0;
  longint m_a[6][6];
  longint m_b[6];
  bit m_mode;
  mat_t m_last;
  mat_t zero_m = '0;
  bit prev = 1'b0;
  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask
  task automatic chk1(string n, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b", n, act, exp);
    end
  endtask
  task automatic chk_mat(string n, mat_t act, mat_t exp);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        chk($sformatf("%s[%0d][%0d]", n, r, c), act[r][c], exp[r][c]);
  endtask
  task automatic model_add(longint gx, longint gy, longint x, longint y, longint d);
    longint c[6];
    if (m_mode) c = '{gx, x * gx, gy, x * gy, y * gx, y * gy};
    else c = '{0, 0, x * gx + y * gy, y * gx - x * gy, gx, gy};
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6; j++) m_a[i][j] += c[i] * c[j];
      m_b[i] += c[i] * d;
    end
  endtask
  function automatic mat_t model_mat();
    mat_t m;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 6; c++) m[r][c] = m_a[r][c];
      m[r][6] = m_b[r];
    end
    return m;
  endfunction
  task automatic start(bit m);
    bus.accum_init_i = 1'b1;
    bus.affine_param6_i = m;
    @(negedge clk);
    bus.accum_init_i = 1'b0;
    m_mode = m;
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6; j++) m_a[i][j] = 0;
      m_b[i] = 0;
    end
  endtask
  task automatic send(longint gx, longint gy, longint x, longint y, longint d, bit last, int bubbles);
    repeat (bubbles) begin
      bus.sample_gx_i = 16'($urandom);
      @(negedge clk);
    end
    bus.sample_gx_i = gx[15:0];
    bus.sample_gy_i = gy[15:0];
    bus.sample_x_i = x[7:0];
    bus.sample_y_i = y[7:0];
    bus.sample_diff_i = d[15:0];
    bus.sample_last_i = last;
    bus.sample_valid_i = 1'b1;
    chk1("sample_ready", bus.sample_ready_o, 1'b1);
    model_add(gx, gy, x, y, d);
    if (last) begin
      m_last = model_mat();
      q.push_back(m_last);
      qm.push_back(m_mode);
    end
    @(negedge clk);
    bus.sample_valid_i = 1'b0;
    bus.sample_last_i = 1'b0;
  endtask
  task automatic wait_hold();
    int n = 0;
    while (!bus.comp_init_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk1("hold_reached", bus.comp_init_o, 1'b1);
  endtask
  task automatic done();
    bus.comp_done_i = 1'b1;
    @(negedge clk);
    bus.comp_done_i = 1'b0;
    chk1("init_low_after_done", bus.comp_init_o, 1'b0);
  endtask
  function automatic longint rg();
    return longint'($urandom_range(0, 65535)) - 32768;
  endfunction
  // scoreboard monitor: every rising comp_init_o must match the oldest expected block
  initial forever begin
    @(negedge clk);
    if (bus.comp_init_o && !prev) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_hold actual=1 required=0");
      end else begin
        chk_mat("sb", bus.comp_data_o, q.pop_front());
        chk1("sb_mode", bus.affine_param6_o, qm.pop_front());
      end
    end
    prev = bus.comp_init_o;
  end
  initial begin
    bus.accum_init_i = 0; bus.affine_param6_i = 0; bus.sample_valid_i = 0; bus.sample_last_i = 0;
    bus.sample_gx_i = 0; bus.sample_gy_i = 0; bus.sample_x_i = 0; bus.sample_y_i = 0;
    bus.sample_diff_i = 0; bus.comp_done_i = 0;
    bus2.accum_init_i = 0; bus2.affine_param6_i = 0; bus2.sample_valid_i = 0; bus2.sample_last_i = 0;
    bus2.sample_gx_i = 0; bus2.sample_gy_i = 0; bus2.sample_x_i = 0; bus2.sample_y_i = 0;
    bus2.sample_diff_i = 0; bus2.comp_done_i = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk1("rst_ready", bus.sample_ready_o, 1'b0);
    chk1("rst_init", bus.comp_init_o, 1'b0);
    chk1("rst_mode", bus.affine_param6_o, 1'b0);
    chk_mat("rst_data", bus.comp_data_o, zero_m);
    start(1'b1);
    send(1, 2, 3, 4, 5, 1'b1, 0);
    for (int n = 0; n < 3; n++) begin
      chk1("init_latency_low", bus.comp_init_o, 1'b0);
      @(negedge clk);
    end
    chk1("init_latency_high", bus.comp_init_o, 1'b1);
    chk("t1_a13", bus.comp_data_o[1][3], 18);
    chk("t1_a31", bus.comp_data_o[3][1], 18);
    chk("t1_a55", bus.comp_data_o[5][5], 64);
    chk("t1_a00", bus.comp_data_o[0][0], 1);
    chk("t1_b0", bus.comp_data_o[0][6], 5);
    chk("t1_b5", bus.comp_data_o[5][6], 40);
    chk1("t1_mode", bus.affine_param6_o, 1'b1);
    bus.sample_valid_i = 1'b1;
    bus.sample_last_i = 1'b1;
    bus.sample_gx_i = 16'sd77;
    bus.accum_init_i = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk1("hold_ready_low", bus.sample_ready_o, 1'b0);
      chk1("hold_init_high", bus.comp_init_o, 1'b1);
    end
    chk_mat("hold_data", bus.comp_data_o, m_last);
    bus.sample_valid_i = 1'b0;
    bus.sample_last_i = 1'b0;
    bus.accum_init_i = 1'b0;
    done();
    start(1'b0);
    chk_mat("clear_data", bus.comp_data_o, zero_m);
    send(1, 2, 3, 4, 5, 1'b1, 0);
    wait_hold();
    chk("t2_a22", bus.comp_data_o[2][2], 121);
    chk("t2_a23", bus.comp_data_o[2][3], -22);
    chk("t2_a32", bus.comp_data_o[3][2], -22);
    chk("t2_a45", bus.comp_data_o[4][5], 2);
    chk("t2_b3", bus.comp_data_o[3][6], -10);
    chk1("t2_mode", bus.affine_param6_o, 1'b0);
    done();
    start(1'b1);
    send(-1, 0, 0, 0, 3, 1'b0, 0);
    send(-1, 0, 2, 0, -3, 1'b1, 1);
    wait_hold();
    chk("t3_a00", bus.comp_data_o[0][0], 2);
    chk("t3_a01", bus.comp_data_o[0][1], 2);
    chk("t3_a11", bus.comp_data_o[1][1], 4);
    chk("t3_b0", bus.comp_data_o[0][6], 0);
    chk("t3_b1", bus.comp_data_o[1][6], 6);
    done();
    start(1'b1);
    send(rg(), rg(), 5, 6, rg(), 1'b0, 0);
    send(rg(), rg(), 7, 8, rg(), 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk1("midrst_ready", bus.sample_ready_o, 1'b0);
    chk1("midrst_init", bus.comp_init_o, 1'b0);
    chk1("midrst_mode", bus.affine_param6_o, 1'b0);
    chk_mat("midrst_data", bus.comp_data_o, zero_m);
    start(1'b1);
    send(rg(), rg(), longint'($urandom_range(0, 255)), longint'($urandom_range(0, 255)), rg(), 1'b1, 0);
    wait_hold();
    done();
    for (int b = 0; b < 6; b++) begin
      int len = $urandom_range(1, 6);
      start(1'($urandom));
      for (int s = 0; s < len; s++)
        send(rg(), rg(), longint'($urandom_range(0, 255)), longint'($urandom_range(0, 255)), rg(),
             s == len - 1, $urandom_range(0, 2));
      wait_hold();
      done();
    end
    bus2.accum_init_i = 1'b1;
    bus2.affine_param6_i = 1'b1;
    @(negedge clk);
    bus2.accum_init_i = 1'b0;
    bus2.sample_gx_i = 32'sh80000000;
    bus2.sample_valid_i = 1'b1;
    @(negedge clk);
    bus2.sample_last_i = 1'b1;
    @(negedge clk);
    bus2.sample_valid_i = 1'b0;
    bus2.sample_last_i = 1'b0;
    for (int n = 0; n < 20 && !bus2.comp_init_o; n++) @(negedge clk);
    chk1("wrap_hold", bus2.comp_init_o, 1'b1);
    chk("wrap_a00", bus2.comp_data_o[0][0], 64'h8000000000000000);
    bus2.comp_done_i = 1'b1;
    @(negedge clk);
    bus2.comp_done_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
